// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state encoding,
// default drain depth, bubble NOP encoding and the per-stage control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_ST_RUN    = 2'd0,
    PC_ST_MWAIT  = 2'd1,
    PC_ST_DRAIN  = 2'd2,
    PC_ST_HALTED = 2'd3
  } pc_state_e;

  // DEC-to-WB pipeline gap; default number of drain cycles.
  localparam int unsigned PPGAP_DEC2WB = 4;

  // Instruction word loaded into a stage register when a bubble is inserted.
  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

  typedef struct packed {
    logic stall_if;
    logic stall_dec;
    logic stall_ex;
    logic stall_mem;
    logic bubble_ex;
    logic bubble_wb;
    logic flush_if;
    logic flush_dec;
    logic pc_load;
    logic halted;
  } pc_ctrl_t;

  // Width of a down-counter that holds values 0..cycles-1 (at least 1 bit).
  function automatic int unsigned drain_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counter: counts enabled cycles, sticks at all-ones.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush/bubble from hazards, memory wait
// and debug halt. Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = PPGAP_DEC2WB,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ddep_conflict_i,
  input  logic             br_taken_i,
  input  logic             mem_busy_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             stall_if_o,
  output logic             stall_dec_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             bubble_ex_o,
  output logic             bubble_wb_o,
  output logic             flush_if_o,
  output logic             flush_dec_o,
  output logic             pc_load_o,
  output logic             halted_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned    DW         = drain_cnt_w(DRAIN_CYCLES);
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  pc_state_e     state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          halt_lat, halt_lat_nxt;
  logic          halt_pend;
  pc_ctrl_t      ctl;

  assign halt_pend = halt_lat | halt_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PC_ST_RUN;
      drain_cnt <= '0;
      halt_lat  <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      halt_lat  <= halt_lat_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    halt_lat_nxt  = halt_lat;
    unique case (state)
      PC_ST_RUN: begin
        if (mem_busy_i) begin
          state_nxt = PC_ST_MWAIT;
        end else if (!br_taken_i && halt_pend) begin
          state_nxt     = PC_ST_DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      PC_ST_MWAIT: begin
        if (!mem_busy_i) begin
          if (halt_lat) begin
            state_nxt     = PC_ST_DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
          end else begin
            state_nxt = PC_ST_RUN;
          end
        end
      end
      PC_ST_DRAIN: begin
        // A taken branch refills DEC..WB, so the drain restarts from full length.
        if (mem_busy_i) begin
          state_nxt = PC_ST_MWAIT;
        end else if (br_taken_i) begin
          drain_cnt_nxt = DRAIN_LOAD;
        end else if (!ddep_conflict_i) begin
          if (drain_cnt == '0) begin
            state_nxt = PC_ST_HALTED;
          end else begin
            drain_cnt_nxt = drain_cnt - DW'(1);
          end
        end
      end
      PC_ST_HALTED: begin
        if (resume_i) begin
          state_nxt = PC_ST_RUN;
        end
      end
    endcase

    if (state_nxt == PC_ST_HALTED) begin
      halt_lat_nxt = 1'b0;
    end else if (state != PC_ST_HALTED && halt_req_i) begin
      halt_lat_nxt = 1'b1;
    end
  end

  always_comb begin : outputs
    ctl = '0;
    if (state == PC_ST_HALTED) begin
      ctl.stall_if  = 1'b1;
      ctl.stall_dec = 1'b1;
      ctl.stall_ex  = 1'b1;
      ctl.stall_mem = 1'b1;
      ctl.bubble_wb = 1'b1;
      ctl.halted    = 1'b1;
    end else begin
      if (mem_busy_i) begin
        ctl.stall_if  = 1'b1;
        ctl.stall_dec = 1'b1;
        ctl.stall_ex  = 1'b1;
        ctl.stall_mem = 1'b1;
        ctl.bubble_wb = 1'b1;
      end else if (br_taken_i) begin
        ctl.pc_load   = 1'b1;
        ctl.flush_if  = 1'b1;
        ctl.flush_dec = 1'b1;
      end else if (ddep_conflict_i) begin
        ctl.stall_if  = 1'b1;
        ctl.stall_dec = 1'b1;
        ctl.bubble_ex = 1'b1;
      end
      if (state == PC_ST_DRAIN) begin
        ctl.stall_if = 1'b1;
        ctl.flush_if = 1'b1;
      end
    end
  end

  assign stall_if_o  = ctl.stall_if;
  assign stall_dec_o = ctl.stall_dec;
  assign stall_ex_o  = ctl.stall_ex;
  assign stall_mem_o = ctl.stall_mem;
  assign bubble_ex_o = ctl.bubble_ex;
  assign bubble_wb_o = ctl.bubble_wb;
  assign flush_if_o  = ctl.flush_if;
  assign flush_dec_o = ctl.flush_dec;
  assign pc_load_o   = ctl.pc_load;
  assign halted_o    = ctl.halted;
  assign state_o     = state;

`ifdef PIPE_CTRL_PERF_EN
  // bubble_ex is asserted exactly in cycles where a data conflict stalls DEC.
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctl.bubble_ex),
    .cnt   (stall_cnt_o)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctl.pc_load),
    .cnt   (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: behavioural model compared every cycle, plus
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_pipe_ctrl;

  localparam int DC = 4;
  localparam int CW = 16;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ddep, br, busy, halt, resume;
  logic stall_if, stall_dec, stall_ex, stall_mem, bubble_ex, bubble_wb;
  logic flush_if, flush_dec, pc_load, halted;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ddep_conflict_i(ddep), .br_taken_i(br), .mem_busy_i(busy),
    .halt_req_i(halt), .resume_i(resume),
    .stall_if_o(stall_if), .stall_dec_o(stall_dec), .stall_ex_o(stall_ex),
    .stall_mem_o(stall_mem), .bubble_ex_o(bubble_ex), .bubble_wb_o(bubble_wb),
    .flush_if_o(flush_if), .flush_dec_o(flush_dec), .pc_load_o(pc_load),
    .halted_o(halted), .state_o(state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: waiting / draining / halted flags, remaining clean drain cycles, pending halt.
  bit m_wait, m_drain, m_halted, m_pend;
  int m_left, m_scnt, m_fcnt;

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 1'b0; m_drain <= 1'b0; m_halted <= 1'b0; m_pend <= 1'b0;
      m_left <= 0; m_scnt <= 0; m_fcnt <= 0;
    end else begin : upd
      bit nw, nd, nh, np;
      int nl, ns, nf;
      nw = m_wait; nd = m_drain; nh = m_halted; np = m_pend;
      nl = m_left; ns = m_scnt; nf = m_fcnt;
      if (m_halted) begin
        if (resume) nh = 1'b0;
      end else begin
        if (halt) np = 1'b1;
        if (busy) begin
          nw = 1'b1; nd = 1'b0;
        end else begin
          if (br) nf = sat_inc(nf);
          else if (ddep) ns = sat_inc(ns);
          if (m_wait) begin
            nw = 1'b0;
            if (m_pend) begin nd = 1'b1; nl = DC; end
          end else if (m_drain) begin
            if (br) nl = DC;
            else if (!ddep) begin
              nl = m_left - 1;
              if (nl == 0) begin nd = 1'b0; nh = 1'b1; np = 1'b0; end
            end
          end else if (!br && (m_pend || halt)) begin
            nd = 1'b1; nl = DC;
          end
        end
      end
      m_wait <= nw; m_drain <= nd; m_halted <= nh; m_pend <= np;
      m_left <= nl; m_scnt <= ns; m_fcnt <= nf;
    end
  end

  // Bit order: stall_if, stall_dec, stall_ex, stall_mem, bubble_ex, bubble_wb,
  //            flush_if, flush_dec, pc_load, halted
  function automatic logic [9:0] exp_ctl();
    logic si, sd, se, sm, bx, bw, fi, fd, pl, h;
    {si, sd, se, sm, bx, bw, fi, fd, pl, h} = '0;
    if (m_halted) begin
      {si, sd, se, sm, bw, h} = '1;
    end else begin
      if (busy)      {si, sd, se, sm, bw} = '1;
      else if (br)   {pl, fi, fd} = '1;
      else if (ddep) {si, sd, bx} = '1;
      if (m_drain) begin si = 1'b1; fi = 1'b1; end
    end
    return {si, sd, se, sm, bx, bw, fi, fd, pl, h};
  endfunction

  function automatic int exp_state();
    return m_halted ? 3 : m_drain ? 2 : m_wait ? 1 : 0;
  endfunction

  wire [9:0] act_ctl = {stall_if, stall_dec, stall_ex, stall_mem, bubble_ex,
                        bubble_wb, flush_if, flush_dec, pc_load, halted};

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ctl", {22'd0, act_ctl}, {22'd0, exp_ctl()});
      check("model_state", {30'd0, state}, exp_state());
      check("model_stall_cnt", {16'd0, stall_cnt}, PERF ? m_scnt : 0);
      check("model_flush_cnt", {16'd0, flush_cnt}, PERF ? m_fcnt : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ddep = 1'b0; br = 1'b0; busy = 1'b0; halt = 1'b0; resume = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw, de, hi;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    check("reset_outs", {22'd0, act_ctl}, 32'd0);
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_cnts", {stall_cnt, flush_cnt}, 32'd0);

    // Two-cycle data conflict.
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); ddep = (i < 2);
      @(negedge clk);
      if (stall_if && stall_dec && bubble_ex) nw++;
    end
    check("ddep_stall_cycles", nw, 2);
    check("ddep_stall_cnt", {16'd0, stall_cnt}, PERF ? 32'd2 : 32'd0);

    // Branch overrides the conflict in the same cycle.
    tick(); br = 1'b1; ddep = 1'b1;
    @(negedge clk);
    check("br_ddep_ctl", {27'd0, pc_load, flush_if, flush_dec, stall_if, bubble_ex}, 32'b11100);
    tick(); idle();
    @(negedge clk);
    check("br_flush_cnt", {16'd0, flush_cnt}, PERF ? 32'd1 : 32'd0);

    // Memory wait of 3 cycles with a halt request in the first.
    nw = 0; de = -1; hi = -1;
    for (int i = 0; i < 20; i++) begin
      tick(); busy = (i < 3); halt = (i == 0);
      @(negedge clk);
      if (state == 2'd1) nw++;
      if (state == 2'd2 && de < 0) de = i;
      if (halted && hi < 0) hi = i;
    end
    check("mwait_cycles", nw, 3);
    check("mwait_drain_entry", de, 4);
    check("mwait_drain_to_halt", hi - de, DC);

    // HALTED ignores busy and branch.
    tick(); busy = 1'b1; br = 1'b1; ddep = 1'b1;
    @(negedge clk);
    check("halted_ignores", {26'd0, pc_load, stall_if, stall_dec, stall_ex, stall_mem, halted}, 32'b011111);
    tick(); idle(); resume = 1'b1; halt = 1'b1;
    @(negedge clk);
    check("resume_cycle_state", {30'd0, state}, 32'd3);
    tick(); idle();
    @(negedge clk);
    check("resume_state", {30'd0, state}, 32'd0);
    check("resume_stalls", {27'd0, stall_if, stall_dec, stall_ex, stall_mem, halted}, 32'd0);
    tick(); tick();
    @(negedge clk);
    check("resume_halt_ignored", {30'd0, state}, 32'd0);

    // Clean halt latency.
    hi = -1;
    for (int i = 0; i < 16; i++) begin
      tick(); halt = (i == 0);
      @(negedge clk);
      if (halted && hi < 0) hi = i;
    end
    check("halt_latency", hi, DC + 1);
    tick(); resume = 1'b1;
    tick(); idle();

    // Branch while the drain counter is at 1 restarts the drain.
    de = -1; hi = -1;
    for (int i = 0; i < 16; i++) begin
      tick(); halt = (i == 0); br = (i == 3);
      @(negedge clk);
      if (state == 2'd2 && de < 0) de = i;
      if (halted && hi < 0) hi = i;
    end
    check("drain_br_entry", de, 1);
    check("drain_br_halt", hi, 8);
    tick(); resume = 1'b1;
    tick(); idle();

    // Asynchronous reset in the middle of a drain.
    tick(); halt = 1'b1;
    tick(); halt = 1'b0;
    tick();
    check("pre_reset_drain", {30'd0, state}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_state", {30'd0, state}, 32'd0);
    check("async_reset_outs", {22'd0, act_ctl}, 32'd0);
    check("async_reset_cnts", {stall_cnt, flush_cnt}, 32'd0);
    #1 rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      ddep   = ($urandom_range(0, 99) < 30);
      br     = ($urandom_range(0, 99) < 15);
      busy   = ($urandom_range(0, 99) < 15);
      halt   = ($urandom_range(0, 99) < 4);
      resume = ($urandom_range(0, 99) < 20);
    end
    tick(); idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
